core_insn_loader: RTL
=====================

# core_insn_loader

Per-core receiving end of the scheduler's instruction-load interface. The block:
- captures the `Start` / `Insn_Load_Counter` / `Insn_Data` beat stream into a local instruction buffer;
- latches the task's initial R0;
- launches the core's executor once loading ends;
- drives the core's `Ready` bit back to the scheduler.

One instance sits in front of each core, between the scheduler buses and the core's fetch stage.

## Interface
Parameters:
- `INSN_W`, 32: width of one `Insn_Data` beat.
- `LOAD_TIME`, 4: beats per instruction frame. Must match the scheduler's `INSN_LOAD_TIME`.
- `CNT_W`, clog2(`LOAD_TIME`): width of `Insn_Load_Counter`.
- `FRAMES_MAX`, 16: buffer capacity in frames. Depth `D` = `FRAMES_MAX`*`LOAD_TIME` beats.
- `REG_W`, 8: R0 width.

Ports:
- `clk`  in  1  clock. One clock for the whole block.
- `reset`  in  1  reset. Synchronous and active-low: state resets on a `clk` edge where `reset`==0.
- `start_i`  in  1  this core's `Start` bit.
- `load_cnt_i`  in  `CNT_W`  `Insn_Load_Counter`.
- `insn_data_i`  in  `INSN_W`  `Insn_Data` beat.
- `init_r0_en_i`  in  1  this core's `Init_R0_Vect` bit.
- `init_r0_i`  in  `REG_W`  this core's slice of `Init_R0`.
- `core_done_i`  in  1  executor finished the task (1-cycle pulse).
- `rd_addr_i`  in  clog2(`D`)  fetch address, in beats.
- `rd_data_o`  out  `INSN_W`  fetch data, 1-cycle latency.
- `ready_o`  out  1  to the scheduler's `Ready` bit.
- `run_o`  out  1  executor launch pulse.
- `insn_len_o`  out  clog2(`D`)+1  beats loaded for the current task.
- `r0_we_o`  out  1  R0 write strobe.
- `r0_o`  out  `REG_W`  R0 write value.
- `load_err_o`  out  1  sticky error flag.

## Operation
States: IDLE, LOAD, LAUNCH, BUSY.
- `ready_o` = (state==IDLE or state==LOAD). It is decoded from the state register only, with no input path.
- A beat is `start_i`==1 while in IDLE or LOAD.
  - Beat write address = `frame_cnt`*`LOAD_TIME` + `load_cnt_i`.
  - `frame_cnt` increments when a beat has `load_cnt_i`==`LOAD_TIME`-1.
  - `beat_cnt` increments on every beat.
- IDLE:
  - `start_i`=1 → LOAD. Clear `frame_cnt`, `beat_cnt` and `load_err_o`. The entry beat is written at `frame_cnt`=0.
- LOAD:
  - `start_i`=1 → stay in LOAD and write the beat.
  - `start_i`=0 → LAUNCH. Register `insn_len_o` = `beat_cnt`.
- LAUNCH (exactly 1 cycle):
  - `run_o`=1.
  - `r0_we_o` = `init_r0_en_i`, `r0_o` = `init_r0_i`.
  - → BUSY.
- BUSY:
  - `core_done_i`=1 → IDLE.
  - `start_i` is ignored in LAUNCH and BUSY, and `load_err_o` is set if it is seen.
- Overflow: a beat whose address is ≥ `D` is dropped, not written, and sets `load_err_o`. `beat_cnt` saturates at `D`.
- Partial frame: leaving LOAD with `beat_cnt` mod `LOAD_TIME` ≠ 0 sets `load_err_o`. Launch still happens.
- Non-sequential `load_cnt_i` within a frame is written as addressed, with no check.
- A `core_done_i` arriving in IDLE, LOAD or LAUNCH is ignored.

## Timing
- Reset values: state IDLE, `ready_o`=1, `run_o`=0, `r0_we_o`=0, `r0_o`=0, `insn_len_o`=0, `load_err_o`=0, counters 0. Buffer contents are not cleared.
- Reset mid-LOAD or mid-BUSY returns to IDLE on the next edge. No `run_o` is issued.
- A beat at edge t is readable via `rd_addr_i` from edge t+1, with data at t+2.
- Last beat at cycle t, `start_i` low at t+1:
  - LAUNCH at t+2, so `ready_o` falls at t+2.
  - The scheduler cannot issue a new `Start` to this core at t+2.
- BUSY with `core_done_i` at t gives `ready_o`=1 at t+1.
- Simultaneous `start_i`=1 and `core_done_i`=1 in BUSY: the transition to IDLE wins, the start is ignored and flagged.
- Registered outputs: `run_o`, `r0_we_o`, `r0_o`, `insn_len_o`, `load_err_o`.

## Structure
- Constants `INSN_LOAD_TIME`, the insn bus width and `REG_W` come from the shared range definitions. Defaults are bound to them.
- State encoding goes in a shared core-side definitions include.
- Sub-module `core_insn_buf`: 1-write/1-read synchronous RAM, `D` x `INSN_W`, registered read.

## Test plan
- 2 frames (8 beats `0xA0..0xA7`, `load_cnt` 0-3 twice), then `start_i` low, `init_r0_en_i`=1, `init_r0_i`=0x5C → `run_o` pulse 2 cycles after the last beat; `r0_we_o`=1 with `r0_o`=0x5C; `insn_len_o`=8; reads of 0..7 return `0xA0..0xA7`; `ready_o` 0 until `core_done_i`.
- 17 frames at `FRAMES_MAX`=16 → first 64 beats stored, beats 64-67 dropped; `load_err_o`=1; `insn_len_o`=64.
- 6 beats (frame 2 ends at `load_cnt`=1) → `load_err_o`=1, `insn_len_o`=6, `run_o` still pulses.
- `start_i` pulsed during BUSY → no buffer write, `load_err_o`=1; `core_done_i` → `ready_o`=1 next cycle.
- `reset`=0 in the middle of LOAD → next cycle IDLE with `ready_o`=1; `run_o` never asserts; a new 1-frame load then launches normally with `load_err_o`=0.
- `init_r0_en_i`=0 at launch → `r0_we_o` stays 0, `run_o`=1.

Source files
------------

// File: rtl/core_insn_loader_pkg.sv
// Shared range constants and core-side state encoding for the instruction loader.
package core_insn_loader_pkg;
  localparam int INSN_LOAD_TIME = 4;
  localparam int LD_INSN_W      = 32;
  localparam int LD_REG_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_BUSY
  } core_state_e;
endpackage

// File: rtl/core_insn_loader_if.sv
// Scheduler-to-core instruction-load bus, one core's slice.
interface core_insn_loader_if #(
  parameter int CNT_W  = 2,
  parameter int INSN_W = 32,
  parameter int REG_W  = 8
);
  logic              start_i;
  logic [CNT_W-1:0]  load_cnt_i;
  logic [INSN_W-1:0] insn_data_i;
  logic              init_r0_en_i;
  logic [REG_W-1:0]  init_r0_i;
  logic              ready_o;

  modport master (output start_i, load_cnt_i, insn_data_i, init_r0_en_i, init_r0_i,
                  input  ready_o);
  modport slave  (input  start_i, load_cnt_i, insn_data_i, init_r0_en_i, init_r0_i,
                  output ready_o);
endinterface

// File: rtl/core_insn_buf.sv
// Local instruction buffer: 1 write / 1 read synchronous RAM with registered read.
module core_insn_buf #(
  parameter int DEPTH = 64,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/core_insn_loader.sv
// Per-core receiver for the scheduler's instruction-load stream: buffers beats,
// latches R0, launches the executor and reports Ready.
module core_insn_loader
  import core_insn_loader_pkg::*;
#(
  parameter int INSN_W     = LD_INSN_W,
  parameter int LOAD_TIME  = INSN_LOAD_TIME,
  parameter int CNT_W      = (LOAD_TIME > 1) ? $clog2(LOAD_TIME) : 1,
  parameter int FRAMES_MAX = 16,
  parameter int REG_W      = LD_REG_W,
  localparam int D         = FRAMES_MAX * LOAD_TIME,
  localparam int AW        = $clog2(D)
) (
  input  logic                 clk,
  input  logic                 reset,
  core_insn_loader_if.slave    ld,
  input  logic                 core_done_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [INSN_W-1:0]    rd_data_o,
  output logic                 run_o,
  output logic [AW:0]          insn_len_o,
  output logic                 r0_we_o,
  output logic [REG_W-1:0]     r0_o,
  output logic                 load_err_o
);
  localparam int FW = $clog2(FRAMES_MAX + 1);
  localparam int XW = AW + 2;

  core_state_e state, state_nxt;
  logic [FW-1:0] frame_cnt, frame_base;
  logic [AW:0]   beat_cnt, beat_base;
  logic [XW-1:0] addr;
  logic          loading, beat, ovf, frame_last, partial, to_launch, err_nxt;

  assign loading    = (state == ST_IDLE) || (state == ST_LOAD);
  assign ld.ready_o = loading;
  assign beat       = ld.start_i && loading;
  // The entry beat out of IDLE always lands in frame 0, whatever the stale counters hold.
  assign frame_base = (state == ST_IDLE) ? '0 : frame_cnt;
  assign beat_base  = (state == ST_IDLE) ? '0 : beat_cnt;
  assign addr       = XW'(frame_base) * XW'(LOAD_TIME) + XW'(ld.load_cnt_i);
  assign ovf        = addr >= XW'(D);
  assign frame_last = ld.load_cnt_i == CNT_W'(LOAD_TIME - 1);
  assign partial    = (beat_cnt % (AW+1)'(LOAD_TIME)) != '0;
  assign to_launch  = (state == ST_LOAD) && !ld.start_i;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ld.start_i)  state_nxt = ST_LOAD;
      ST_LOAD:   if (!ld.start_i) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_BUSY;
      ST_BUSY:   if (core_done_i) state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    err_nxt = (state == ST_IDLE && ld.start_i) ? 1'b0 : load_err_o;
    if (beat && ovf)                 err_nxt = 1'b1;
    if (ld.start_i && !loading)      err_nxt = 1'b1;
    if (to_launch && partial)        err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt  <= '0;
      beat_cnt   <= '0;
      run_o      <= 1'b0;
      r0_we_o    <= 1'b0;
      r0_o       <= '0;
      insn_len_o <= '0;
      load_err_o <= 1'b0;
    end else begin
      run_o      <= 1'b0;
      r0_we_o    <= 1'b0;
      load_err_o <= err_nxt;
      if (beat) begin
        beat_cnt  <= (beat_base == (AW+1)'(D)) ? beat_base : beat_base + 1'b1;
        frame_cnt <= (frame_last && frame_base != FW'(FRAMES_MAX)) ? frame_base + 1'b1
                                                                    : frame_base;
      end
      if (to_launch) begin
        run_o      <= 1'b1;
        r0_we_o    <= ld.init_r0_en_i;
        r0_o       <= ld.init_r0_i;
        insn_len_o <= beat_cnt;
      end
    end
  end

  core_insn_buf #(.DEPTH(D), .W(INSN_W), .AW(AW)) u_buf (
    .clk     (clk),
    .we      (beat && !ovf),
    .wr_addr (addr[AW-1:0]),
    .wr_data (ld.insn_data_i),
    .rd_addr (rd_addr_i),
    .rd_data (rd_data_o)
  );
endmodule
